// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous sprite ROM among NUM_REQ draw
// engines. Round-robin grant (one read per clock), registered ROM address,
// and a tagged fixed-latency return path back to the owning engine.
// Optional build macro SPRITE_ARB_FIXED_PRI_EN: requester 0 (player tank)
// always wins when requesting and does not move the round-robin pointer.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = 1 + ROM_LAT;

  logic [PTR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]  r_rom_address;
  logic [DEPTH-1:0]   r_tag_vld;
  logic [NUM_REQ-1:0] r_tag_id [DEPTH];
  logic [NUM_REQ-1:0] r_rd_valid;
  logic [DATA_W-1:0]  r_rd_data;

  logic [NUM_REQ-1:0] w_rr_req;
  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_grant;
  logic               w_move_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;

  // Requesters taking part in the rotating search (requester 0 is pulled
  // out of the rotation when it has fixed priority).
  always_comb begin
    w_rr_req = req;
`ifdef SPRITE_ARB_FIXED_PRI_EN
    w_rr_req[0] = 1'b0;
`endif
  end

  // Winner select: first requester at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rr_req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
`ifdef SPRITE_ARB_FIXED_PRI_EN
    if (req[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
`endif
  end

  // One-hot grant; forced low while reset is held so nothing is granted.
  always_comb begin
    w_gnt = '0;
    if (reset_n && en && w_found) begin
      w_gnt[w_win] = 1'b1;
    end
  end

  assign gnt     = w_gnt;
  assign w_grant = |w_gnt;

  // Pointer advance decision and next value (winner + 1, wrapping).
  always_comb begin
`ifdef SPRITE_ARB_FIXED_PRI_EN
    w_move_ptr = w_grant && !req[0];
`else
    w_move_ptr = w_grant;
`endif
    w_ptr_nxt = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  end

  // Round-robin pointer register; frozen in cycles without a grant.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (w_move_ptr) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Issue the winner's address to the ROM; hold it otherwise.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_address <= '0;
    end else if (w_grant) begin
      r_rom_address <= addr[int'(w_win)*ADDR_W +: ADDR_W];
    end
  end

  // Tag pipeline: carries the owner of each read alongside the ROM latency.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_vld <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_vld   <= {r_tag_vld[DEPTH-2:0], w_grant};
      r_tag_id[0] <= w_gnt;
      for (int s = 1; s < DEPTH; s++) begin
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  // Return stage: capture ROM data for the tagged owner; data holds when idle.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= '0;
      r_rd_data  <= '0;
    end else if (r_tag_vld[DEPTH-1]) begin
      r_rd_valid <= r_tag_id[DEPTH-1];
      r_rd_data  <= rom_q;
    end else begin
      r_rd_valid <= '0;
    end
  end

  assign rom_address = r_rom_address;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign busy        = (|r_tag_vld) || (|r_rd_valid);

`ifndef SYNTHESIS
  // A grant must never name more than one requester.
  a_gnt_onehot: assert property (@(posedge vga_clk) disable iff (!reset_n) $onehot0(gnt));
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Testbench for sprite_rom_arbiter: vector table, directed multi-cycle
// sequences, and randomized traffic checked against a queue-based model.
module tb_sprite_rom_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;
  localparam int ROM_LAT = 1;

  logic                      vga_clk;
  logic                      reset_n;
  logic                      en;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic                      busy;

  sprite_rom_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .en(en), .req(req), .addr(addr),
    .gnt(gnt), .rom_address(rom_address), .rom_q(rom_q),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Sprite ROM stand-in: palette index is the low address byte, one clock late.
  always @(posedge vga_clk) rom_q <= rom_address[DATA_W-1:0];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int                 due;
    int                 gcyc;
    logic [NUM_REQ-1:0] id;
    logic [DATA_W-1:0]  data;
  } pend_t;

  pend_t             pq[$];
  int                m_ptr;
  logic [ADDR_W-1:0] m_rom;
  logic [DATA_W-1:0] m_rd;

  logic [NUM_REQ-1:0] s_gnt, s_rv, s_exp_gnt;
  logic [DATA_W-1:0]  s_rd;
  logic [ADDR_W-1:0]  s_ra;
  logic               s_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int model_winner(input logic [NUM_REQ-1:0] r, input int p);
`ifdef SPRITE_ARB_FIXED_PRI_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (p + k) % NUM_REQ;
`ifdef SPRITE_ARB_FIXED_PRI_EN
      if (i == 0) continue;
`endif
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
    addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  // One clock: check every output at the falling edge against the model,
  // advance the model, then return 1 time unit after the rising edge.
  task automatic tick();
    logic [NUM_REQ-1:0] eg, erv;
    logic               eb;
    int                 w;
    @(negedge vga_clk);
    if (!reset_n) begin
      pq.delete();
      m_ptr = 0;
      m_rom = '0;
      m_rd  = '0;
    end
    eg = '0;
    w  = -1;
    if (reset_n && en) begin
      w = model_winner(req, m_ptr);
      if (w >= 0) eg[w] = 1'b1;
    end
    erv = '0;
    eb  = 1'b0;
    foreach (pq[j]) begin
      if (pq[j].due == cyc) begin
        erv  = erv | pq[j].id;
        m_rd = pq[j].data;
      end
      if (pq[j].gcyc < cyc && cyc <= pq[j].due) eb = 1'b1;
    end
    s_gnt  = gnt;
    s_rv   = rd_valid;
    s_rd   = rd_data;
    s_ra   = rom_address;
    s_busy = busy;
    s_exp_gnt = eg;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("rd_valid", 32'(rd_valid), 32'(erv));
    chk("rd_data", 32'(rd_data), 32'(m_rd));
    chk("rom_address", 32'(rom_address), 32'(m_rom));
    chk("busy", 32'(busy), 32'(eb));
    while (pq.size() > 0 && pq[0].due <= cyc) void'(pq.pop_front());
    if (w >= 0) begin
      pend_t p;
      p.due  = cyc + 2 + ROM_LAT;
      p.gcyc = cyc;
      p.id   = eg;
      p.data = addr[w*ADDR_W +: DATA_W];
      pq.push_back(p);
      m_rom = addr[w*ADDR_W +: ADDR_W];
`ifdef SPRITE_ARB_FIXED_PRI_EN
      if (w != 0) m_ptr = (w + 1) % NUM_REQ;
`else
      m_ptr = (w + 1) % NUM_REQ;
`endif
    end
    @(posedge vga_clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    en      = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic               en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] exp_gnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic e, input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] g);
    vec_t v;
    v.en = e; v.req = r; v.exp_gnt = g;
    return v;
  endfunction

  initial begin
    int cnt;
    logic [NUM_REQ-1:0] rv_hist [12];
    reset_n = 1'b0;
    en      = 1'b0;
    req     = '0;
    addr    = '0;

    // Vector table, applied from a fresh reset (pointer at 0).
`ifdef SPRITE_ARB_FIXED_PRI_EN
    tbl.push_back(mk(1, 4'b0111, 4'b0001));
    tbl.push_back(mk(1, 4'b0111, 4'b0001));
    tbl.push_back(mk(1, 4'b0110, 4'b0010));
    tbl.push_back(mk(1, 4'b0110, 4'b0100));
    tbl.push_back(mk(1, 4'b1110, 4'b1000));
    tbl.push_back(mk(1, 4'b1111, 4'b0001));
    tbl.push_back(mk(1, 4'b1110, 4'b0010));
    tbl.push_back(mk(1, 4'b0000, 4'b0000));
`else
    tbl.push_back(mk(1, 4'b0100, 4'b0100));
    tbl.push_back(mk(1, 4'b1111, 4'b1000));
    tbl.push_back(mk(1, 4'b1111, 4'b0001));
    tbl.push_back(mk(1, 4'b1111, 4'b0010));
    tbl.push_back(mk(0, 4'b1111, 4'b0000));
    tbl.push_back(mk(1, 4'b0001, 4'b0001));
    tbl.push_back(mk(1, 4'b1001, 4'b1000));
    tbl.push_back(mk(1, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 4'b0110, 4'b0010));
    tbl.push_back(mk(1, 4'b0110, 4'b0100));
    tbl.push_back(mk(1, 4'b0011, 4'b0001));
    tbl.push_back(mk(1, 4'b0011, 4'b0010));
`endif

    do_reset();
    chk("reset_busy", 32'(s_busy), 32'h0);
    chk("reset_rd_valid", 32'(s_rv), 32'h0);
    for (int i = 0; i < NUM_REQ; i++) set_addr(i, ADDR_W'(10'h0A0 + i * 17));
    foreach (tbl[k]) begin
      en  = tbl[k].en;
      req = tbl[k].req;
      tick();
      chk("tbl_gnt", 32'(s_gnt), 32'(tbl[k].exp_gnt));
    end
    en = 1'b0; req = '0;
    for (int i = 0; i < 5; i++) tick();

    // Single request: grant, address next cycle, data three cycles after grant.
    do_reset();
    en = 1'b1; req = 4'b0100; set_addr(2, 10'h123);
    tick();
    chk("single_gnt", 32'(s_gnt), 32'b0100);
    req = '0;
    tick();
    chk("single_rom_addr", 32'(s_ra), 32'h123);
    tick();
    tick();
    chk("single_rd_valid", 32'(s_rv), 32'b0100);
    chk("single_rd_data", 32'(s_rd), 32'h23);
    tick();
    chk("single_rv_strobe", 32'(s_rv), 32'h0);
    tick();
    chk("single_busy_idle", 32'(s_busy), 32'h0);

`ifndef SPRITE_ARB_FIXED_PRI_EN
    // All four requesting: grants 0,1,2,3,0 and returns in the same order.
    do_reset();
    en = 1'b1; req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_addr(i, ADDR_W'(10'h310 + i));
    for (int k = 0; k < 10; k++) begin
      if (k == 5) req = '0;
      tick();
      if (k < 5) chk("rr_gnt", 32'(s_gnt), 32'(1 << (k % 4)));
      rv_hist[k] = s_rv;
    end
    for (int k = 0; k < 5; k++) chk("rr_return", 32'(rv_hist[k + 3]), 32'(1 << (k % 4)));

    // Wrap: grant 3 alone, then {3,0} -> 0, then 3.
    do_reset();
    en = 1'b1; req = 4'b1000;
    tick();
    chk("wrap_g3", 32'(s_gnt), 32'b1000);
    req = 4'b1001;
    tick();
    chk("wrap_g0", 32'(s_gnt), 32'b0001);
    req = 4'b1000;
    tick();
    chk("wrap_g3b", 32'(s_gnt), 32'b1000);
    req = '0;
    for (int i = 0; i < 4; i++) tick();

    // en low for two cycles with two reads in flight.
    do_reset();
    en = 1'b1; req = 4'b1111;
    tick();
    tick();
    en = 1'b0;
    tick();
    chk("en0_gnt_a", 32'(s_gnt), 32'h0);
    tick();
    chk("en0_gnt_b", 32'(s_gnt), 32'h0);
    chk("en0_ret0", 32'(s_rv), 32'b0001);
    en = 1'b1; req = '0;
    tick();
    chk("en0_ret1", 32'(s_rv), 32'b0010);
    chk("en0_busy_last", 32'(s_busy), 32'h1);
    tick();
    chk("en0_busy_fall", 32'(s_busy), 32'h0);
    req = 4'b1111;
    tick();
    chk("en0_ptr_kept", 32'(s_gnt), 32'b0100);
    req = '0;
    for (int i = 0; i < 4; i++) tick();
`else
    // Player tank wins while requesting; others then alternate from 1.
    do_reset();
    en = 1'b1; req = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fixed_pri_g0", 32'(s_gnt), 32'b0001);
    end
    req = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fixed_pri_alt", 32'(s_gnt), (k % 2 == 0) ? 32'b0010 : 32'b0100);
    end
    req = '0;
    for (int i = 0; i < 4; i++) tick();
`endif

    // Reset one cycle after a grant: the read never returns.
    do_reset();
    en = 1'b1; req = 4'b0010; set_addr(1, 10'h2C5);
    tick();
    chk("rst_pre_gnt", 32'(s_gnt), 32'b0010);
    reset_n = 1'b0; req = 4'b1111;
    tick();
    chk("rst_gnt", 32'(s_gnt), 32'h0);
    chk("rst_rv", 32'(s_rv), 32'h0);
    chk("rst_rd", 32'(s_rd), 32'h0);
    chk("rst_ra", 32'(s_ra), 32'h0);
    chk("rst_busy", 32'(s_busy), 32'h0);
    reset_n = 1'b1; req = '0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_rv != '0) cnt++;
    end
    chk("rst_dropped_read", 32'(cnt), 32'h0);

    // Randomized traffic against the model; requesters hold until granted.
    do_reset();
    en = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_addr(i, ADDR_W'($urandom));
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && s_exp_gnt[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          set_addr(i, ADDR_W'($urandom));
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          set_addr(i, ADDR_W'($urandom));
        end
      end
      en = ($urandom_range(0, 9) != 0);
    end
    en = 1'b0; req = '0;
    for (int i = 0; i < 5; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM (address in, palette index out) among NUM_REQ sprite draw engines (player tank, enemy tanks, shells).
- Round-robin arbitration issues at most one ROM read per clock.
- Returns each read to its owner through a tagged, fixed-latency pipeline.
- Sits between the per-object sprite engines and the single sprite ROM/palette pair in the VGA pixel path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 10, ROM address width.
- DATA_W, 8, ROM data (palette index) width.
- ROM_LAT, 1, ROM read latency in clocks from address-valid to q-valid (1..3).

Ports:
- vga_clk  in  1  pixel clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  arbitration enable; when low no new grants.
- req  in  NUM_REQ  per-requester read request, held until granted.
- addr  in  NUM_REQ*ADDR_W  packed request addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the winning req.
- rom_address  out  ADDR_W  registered address to the sprite ROM.
- rom_q  in  DATA_W  ROM read data.
- rd_valid  out  NUM_REQ  one-hot, one-cycle strobe marking return data for requester i.
- rd_data  out  DATA_W  registered return data.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - rom_address=0, rd_valid=0, rd_data=0, busy=0.
  - Round-robin pointer=0; tag pipeline cleared.
  - gnt=0 while reset_n low.
- Arbitration (cycle t):
  - Applies when en=1 and req!=0.
  - Winner is the first set req bit searching from pointer upward, wrapping NUM_REQ-1 -> 0.
  - gnt has exactly that bit set; otherwise gnt=0.
  - At the end of t: pointer <= (winner+1) mod NUM_REQ.
  - Pointer unchanged in cycles with no grant.
- Handshake:
  - Requester holds req and addr stable until it sees gnt.
  - It may deassert req or change addr in t+1.
  - Back-to-back grants to the same requester are allowed only when it is the sole requester.
- Issue: on grant, rom_address <= addr[winner] at the end of t (valid during t+1); otherwise rom_address holds its value.
- Tag pipeline:
  - Depth 1+ROM_LAT shift register of {valid, one-hot id}.
  - Stage 0 is loaded at the end of t with {grant, gnt}.
- Return: at the end of cycle t+1+ROM_LAT:
  - rd_data <= rom_q.
  - rd_valid <= id of the final stage if valid, else 0.
  - rd_valid/rd_data are therefore visible during t+2+ROM_LAT.
  - Total latency is 3 cycles at ROM_LAT=1.
  - rd_data holds its value when rd_valid=0.
- Throughput: one grant per cycle sustained; no backpressure on returns. Requesters must accept rd_valid unconditionally.
- busy: OR of all tag-pipeline valid bits plus the rd_valid output register.
- en=0 mid-stream: in-flight reads complete and return normally. Pointer frozen.
- Simultaneous events:
  - Grant and return in the same cycle to the same requester are independent and both occur.
  - A req arriving in the same cycle as en rising is eligible that cycle.
- Reset mid-operation: all in-flight tags are dropped. No rd_valid is produced for reads issued before reset.
- Illegal/unused: req bits >= NUM_REQ do not exist. gnt is never multi-hot (assertion).

Optional Feature:
- Macro: SPRITE_ARB_FIXED_PRI_EN
- Defined:
  - Requester 0 (player tank) wins whenever req[0]=1, regardless of the pointer.
  - Grants to requester 0 do not move the pointer.
  - Other requesters are round-robin among themselves when req[0]=0.
- Undefined: pure round-robin over all requesters as described above.

Test Plan:
- Reset then single request: req=4'b0100, addr[2]=10'h123, ROM model q=addr[7:0].
  - Expect gnt=4'b0100 same cycle.
  - rom_address=10'h123 next cycle.
  - rd_valid=4'b0100, rd_data=8'h23 three cycles after grant.
- All four requesting continuously from pointer=0 -> grants 0,1,2,3,0 on consecutive cycles; five returns in the same order, each 3 cycles after its grant.
- Wrap check: grant 3 alone, then req=4'b1001 -> next grant goes to 0; then to 3 if still requesting.
- en=0 for 2 cycles with req=4'b1111 while two reads are in flight:
  - gnt=0 in both cycles; both pending rd_valid still arrive.
  - busy falls after the last one; pointer unchanged.
- reset_n pulsed low one cycle after a grant -> no rd_valid ever for that read; all outputs 0 during reset.
- With SPRITE_ARB_FIXED_PRI_EN, req=4'b0111 held 4 cycles -> gnt=0001 every cycle. Drop req[0] -> grants alternate 1,2 starting at 1.
